// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Requester count and select width are fixed; data width has a default only.
package arb_pkg;

    localparam int unsigned N_REQ      = 8;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    typedef logic [N_REQ-1:0][DEF_DATA_W-1:0] req_data_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// find the lowest set bit, then add ptr back to get the absolute index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        dbl = {req_i, req_i};
        rot = dbl[ptr_i +: N_REQ];
        off = '0;
        // Scan downwards so the lowest set bit is the one that sticks.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        winner_o = ptr_i + off;
        any_o    = |req_i;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Eight-requester round-robin arbiter feeding a one-entry output register
// with valid/ready handshakes on both sides.
module mux8_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              gnt,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [SEL_W-1:0]              out_sel,
    input  logic                          out_ready
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;

    logic [SEL_W-1:0]    winner;
    logic                any;
    logic                cap_en;
    logic                cap;

    rr_pick8 u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any)
    );

    always_comb begin
        cap_en = (state_q == StIdle) || ((state_q == StHold) && out_ready);
        // Reset suppresses the grant so no requester believes it transferred.
        cap    = cap_en && any && !rst;
        gnt    = cap ? (N_REQ'(1) << winner) : '0;

        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;

        if (cap) begin
            out_data_d  = req_data[winner];
            out_sel_d   = winner;
            ptr_d       = winner + SEL_W'(1);
            state_d     = StHold;
            out_valid_d = 1'b1;
        end else if ((state_q == StHold) && out_ready) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench: directed literal cases plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_mux8_rr_arbiter;
    import arb_pkg::*;

    logic            clk;
    logic            rst;
    logic [7:0]      req;
    req_data_t       req_data;
    logic [7:0]      gnt;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [2:0]      out_sel;
    logic            out_ready;

    int n_chk;
    int n_pass;

    // Behavioural model state: contents of the output slot and the rotate start.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;
    bit         model_ok;

    mux8_rr_arbiter #(
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input logic r, input logic [7:0] rq, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        req       = rq;
        out_ready = rdy;
    endtask

    // Every cycle: outputs must equal the model slot, gnt must equal the model's pick.
    always @(negedge clk) begin
        int         w;
        bit         found;
        bit         cap;
        logic [7:0] eg;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (m_ptr + k) % 8;
            if (!found && req[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        cap = !rst && (!m_valid || out_ready) && found;
        eg  = cap ? (8'd1 << w) : 8'd0;
        chk("model_gnt", 32'(gnt), 32'(eg));
        if (model_ok) begin
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_out_sel", 32'(out_sel), 32'(m_sel));
        end
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = 8'h00;
            m_sel    = 0;
            m_ptr    = 0;
            model_ok = 1'b1;
        end else if (cap) begin
            m_valid = 1'b1;
            m_data  = req_data[w];
            m_sel   = w;
            m_ptr   = (w + 1) % 8;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    initial begin
        int         mode;
        logic [7:0] rq;
        logic       rdy;
        n_chk     = 0;
        n_pass    = 0;
        model_ok  = 1'b0;
        m_valid   = 1'b0;
        m_data    = 8'h00;
        m_sel     = 0;
        m_ptr     = 0;
        rst       = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
        req_data  = '0;

        // Reset state
        cyc(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);

        // Single request, same-cycle grant, one-cycle capture latency
        req_data[2] = 8'hA5;
        cyc(1'b0, 8'h04, 1'b1);
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h04);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_sel", 32'(out_sel), 32'h2);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'h0);
        // Pointer kept at 3 through the drain: requester 3 wins first
        cyc(1'b0, 8'hFF, 1'b1);
        @(negedge clk);
        chk("ptr_after_drain_gnt", 32'(gnt), 32'h08);

        // All requesting: strict rotation with no bubbles
        cyc(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'hFF, 1'b1);
            @(negedge clk);
            chk("rot_gnt", 32'(gnt), 32'(8'd1 << (i % 8)));
            if (i > 0) begin
                chk("rot_sel", 32'(out_sel), 32'((i - 1) % 8));
                chk("rot_valid", 32'(out_valid), 32'h1);
            end
        end

        // Wrap-around from ptr=7
        cyc(1'b1, 8'h00, 1'b1);
        cyc(1'b0, 8'h40, 1'b1);
        @(negedge clk);
        chk("wrap_gnt6", 32'(gnt), 32'h40);
        cyc(1'b0, 8'h03, 1'b1);
        @(negedge clk);
        chk("wrap_gnt0", 32'(gnt), 32'h01);
        chk("wrap_sel6", 32'(out_sel), 32'h6);
        cyc(1'b0, 8'h03, 1'b1);
        @(negedge clk);
        chk("wrap_gnt1", 32'(gnt), 32'h02);
        chk("wrap_sel0", 32'(out_sel), 32'h0);

        // Backpressure holds the slot and the pointer
        cyc(1'b1, 8'h00, 1'b1);
        req_data[5] = 8'h3C;
        cyc(1'b0, 8'h20, 1'b1);
        @(negedge clk);
        chk("bp_cap_gnt", 32'(gnt), 32'h20);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'hFF, 1'b0);
            @(negedge clk);
            chk("bp_gnt", 32'(gnt), 32'h0);
            chk("bp_data", 32'(out_data), 32'h3C);
            chk("bp_sel", 32'(out_sel), 32'h5);
        end
        cyc(1'b0, 8'hFF, 1'b1);
        @(negedge clk);
        chk("bp_release_gnt", 32'(gnt), 32'h40);

        // Mid-operation reset drops the held word
        cyc(1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        chk("mid_pre_valid", 32'(out_valid), 32'h1);
        cyc(1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        cyc(1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_data", 32'(out_data), 32'h0);
        chk("mid_sel", 32'(out_sel), 32'h0);
        chk("mid_first_gnt", 32'(gnt), 32'h01);

        // Randomized traffic; the per-cycle model does the checking
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = $urandom_range(0, 3);
            unique case (mode)
                0:       rq = 8'($urandom & $urandom & $urandom);
                1:       rq = 8'hFF;
                2:       rq = 8'($urandom);
                default: rq = 8'd1 << $urandom_range(0, 7);
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                if (!req[i]) req_data[i] = 8'($urandom);
            end
            rst       = ($urandom_range(0, 199) == 0);
            req       = rq;
            out_ready = rdy;
        end

        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8-bit output channel between eight requesters. Each cycle it selects one pending requester, drives the 3-bit select of the internal 8:1 data mux, and captures the selected byte into a one-entry output register. Input and output use valid/ready handshakes. The block sits between eight producer ports and a single downstream consumer.

## Interface
- DATA_W, 8, width of each requester data word and of out_data
- N_REQ, 8, number of requesters; fixed at 8, with the select width fixed at 3
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  8  req[i] = requester i has valid data
- req_data  input  8 x DATA_W  req_data[i] = data of requester i; must be stable while req[i] is high
- gnt  output  8  one-hot (or zero); combinational; transfer from i occurs on a clock edge where req[i] and gnt[i] are both high
- out_valid  output  1  output register holds a word
- out_data  output  DATA_W  captured word
- out_sel  output  3  index of the requester that supplied out_data
- out_ready  input  1  consumer accepts; handshake completes on an edge where out_valid and out_ready are both high

## Operation
- **State:** FSM states IDLE and HOLD; rotate pointer `ptr[2:0]`.
- **Capture enable:** `cap_en = (state==IDLE) | (state==HOLD & out_ready)`.
- **Winner selection:** winner = first index i with req[i]=1, searching ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
- **gnt:**
  - gnt[winner]=1 only when cap_en and |req.
  - Otherwise gnt=0.
  - Never more than one bit set.
- **On a capture edge:**
  - out_data ← req_data[winner]
  - out_sel ← winner
  - ptr ← winner+1 mod 8 (7 wraps to 0)
  - state ← HOLD
  - out_valid ← 1
- **IDLE:** out_valid=0. If |req, capture and go to HOLD; else stay in IDLE.
- **HOLD:** out_valid=1.
  - !out_ready: registers hold, gnt=0.
  - out_ready & |req: back-to-back capture; stay in HOLD.
  - out_ready & !req: go to IDLE, out_valid ← 0.
- **Fairness:** with all eight requesting continuously, grants rotate 0,1,…,7,0. No requester waits more than 7 captures.
- **Pointer hold:** ptr changes only on capture. Stalls and idle cycles do not move it.
- **Width:** out_sel is a 3-bit unsigned index, with no sign handling. DATA_W only affects data paths.

## Timing
- **Reset values:** while rst=1 at an edge:
  - state=IDLE, ptr=0
  - out_valid=0, out_data=0, out_sel=0
  - gnt forced to 0 during the rst cycle
- **Reset mid-transfer:** the held word is dropped. No gnt is issued in the rst cycle.
- **Latency:** req rising in IDLE at cycle t gives gnt in cycle t and out_valid=1 from cycle t+1.
- **Throughput:** 1 word/cycle when out_ready is held high and req is nonzero.
- **Stall:** out_data and out_sel stay stable while out_valid & !out_ready.
- **Simultaneous output accept and new request:** the new capture happens on the same edge. There is no bubble.
- **Request dropped:** a req deasserted before its grant is simply not considered. No state is kept per requester.

## Structure
- Shared package `arb_pkg`:
  - N_REQ=8, SEL_W=3, DATA_W default
  - state enum {IDLE, HOLD}
  - data array typedef for req_data
- Sub-module `rr_pick8`: purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: winner[2:0], any.
  - Implemented as a rotate, then fixed-priority find-first, then un-rotate.
- The top level holds the FSM, ptr, the output register and the 8:1 data select indexed by winner.

## Test plan
- **Reset and single request:** reset, then req=8'b0000_0100 with req_data[2]=8'hA5 and out_ready=1.
  - Required: gnt=8'h04 in the same cycle.
  - Next cycle: out_valid=1, out_data=8'hA5, out_sel=2.
  - ptr becomes 3.
- **All requesting:** req=8'hFF held with out_ready=1.
  - Required: out_sel sequence 0,1,2,…,7,0,1.
  - One gnt bit per cycle; no idle cycles.
- **Wrap-around:** ptr=7 (after a grant to 6), then req=8'b0000_0011.
  - Required: winner is 0, not 1.
  - ptr becomes 1; the next winner is 1.
- **Backpressure:** capture 8'h3C from requester 5, then out_ready=0 for 4 cycles with req=8'hFF.
  - Required: gnt=0.
  - out_data=8'h3C and out_sel=5 stable throughout.
  - When out_ready rises, the grant goes to requester 6.
- **Drain to IDLE:** in HOLD, out_ready=1 and req=0.
  - Required: out_valid=0 on the next cycle and state IDLE.
  - ptr is unchanged.
- **Mid-operation reset:** assert rst while out_valid=1, out_ready=0 and req=8'hFF.
  - Required: gnt=0 in the rst cycle.
  - Next cycle: out_valid=0, out_data=0, out_sel=0, ptr=0.
  - The first grant after release goes to requester 0.
